// File: rtl/aa_tracker_pkg.sv
// aa_tracker_pkg: shared types and helpers for the aa_exists_tracker slice.
//   op_e      request opcode (LOOKUP/INSERT/DELETE/CLEAR), 2-bit encoded
//   aa_cnt_w  occupancy counter width for a given depth (0..DEPTH inclusive)
//   aa_idx_w  entry index width for a given depth
package aa_tracker_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  function automatic int unsigned aa_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned aa_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/aa_exists_tracker_if.sv
// aa_exists_tracker_if: request/response bus of the associative-array tracker.
//   op_valid/op_ready/op_code/op_key/op_data  request channel (master -> slave)
//   rsp_valid/rsp_ready/rsp_hit/rsp_data/rsp_err  response channel (slave -> master)
// Modports: master (requester side), slave (tracker side).
interface aa_exists_tracker_if #(
  parameter int unsigned KEY_W  = 32,
  parameter int unsigned DATA_W = 32
);

  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [KEY_W-1:0]  op_key;
  logic [DATA_W-1:0] op_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output op_valid, op_code, op_key, op_data, rsp_ready,
    input  op_ready, rsp_valid, rsp_hit, rsp_data, rsp_err
  );

  modport slave (
    input  op_valid, op_code, op_key, op_data, rsp_ready,
    output op_ready, rsp_valid, rsp_hit, rsp_data, rsp_err
  );

endinterface

// File: rtl/aa_tracker_match.sv
// aa_tracker_match: combinational parallel key compare across all entries.
//   key_i        key being searched
//   keys_i       stored keys, one per entry
//   valid_i      entry valid bits
//   hit_o        some valid entry holds key_i
//   hit_idx_o    index of the matching entry (lowest, though at most one exists)
//   free_valid_o at least one entry is free
//   free_idx_o   lowest-index free entry
module aa_tracker_match
  import aa_tracker_pkg::*;
#(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = aa_idx_w(DEPTH)
) (
  input  logic [KEY_W-1:0] key_i,
  input  logic [KEY_W-1:0] keys_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] hit_idx_o,
  output logic             free_valid_o,
  output logic [IDX_W-1:0] free_idx_o
);

  always_comb begin
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    free_valid_o = 1'b0;
    free_idx_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit_o && valid_i[i] && (keys_i[i] == key_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!free_valid_o && !valid_i[i]) begin
        free_valid_o = 1'b1;
        free_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/aa_exists_tracker.sv
// aa_exists_tracker: DEPTH-entry fully associative key/data table with
// lookup, insert, delete and clear, a single registered response slot with
// backpressure, and registered occupancy status.
//   clk, rst   clock and asynchronous active-high reset
//   bus        aa_exists_tracker_if.slave (op_* request, rsp_* response)
//   count      number of valid entries
//   full       count == DEPTH
//   empty      count == 0
// Optional macro AA_TRACKER_SVA_EN enables embedded concurrent assertions.
module aa_exists_tracker
  import aa_tracker_pkg::*;
#(
  parameter int unsigned KEY_W  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W = aa_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  aa_exists_tracker_if.slave bus,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned IDX_W = aa_idx_w(DEPTH);

  typedef struct packed {
    logic              hit;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [KEY_W-1:0]  key_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              rsp_valid_q, rsp_valid_d;
  rsp_t              rsp_q, rsp_d;

  logic              hit, free_valid;
  logic [IDX_W-1:0]  hit_idx, free_idx;
  logic              accept;
  logic              op_ready;
  op_e               op;
  logic              wr_en, wr_key;
  logic [IDX_W-1:0]  wr_idx;

  assign op       = op_e'(bus.op_code);
  assign op_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept   = bus.op_valid && op_ready;

  aa_tracker_match #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH)
  ) u_match (
    .key_i        (bus.op_key),
    .keys_i       (key_q),
    .valid_i      (valid_q),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .free_valid_o (free_valid),
    .free_idx_o   (free_idx)
  );

  // The match runs against the current table, so an op accepted on the
  // cycle after an update already sees that update.
  always_comb begin
    valid_d     = valid_q;
    count_d     = count_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
    wr_en       = 1'b0;
    wr_key      = 1'b0;
    wr_idx      = hit_idx;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_d.hit   = hit;
      rsp_d.err   = 1'b0;
      rsp_d.data  = hit ? data_q[hit_idx] : '0;
      unique case (op)
        OP_LOOKUP: ;
        OP_INSERT: begin
          if (hit) begin
            wr_en = 1'b1;
          end else if (free_valid) begin
            wr_en            = 1'b1;
            wr_key           = 1'b1;
            wr_idx           = free_idx;
            valid_d[free_idx] = 1'b1;
            count_d          = count_q + CNT_W'(1);
          end else begin
            rsp_d.err = 1'b1;
          end
        end
        OP_DELETE: begin
          if (hit) begin
            valid_d[hit_idx] = 1'b0;
            count_d          = count_q - CNT_W'(1);
          end
        end
        OP_CLEAR: begin
          valid_d    = '0;
          count_d    = '0;
          rsp_d.hit  = 1'b0;
          rsp_d.data = '0;
        end
      endcase
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  // Key/data storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= bus.op_data;
      if (wr_key) key_q[wr_idx] <= bus.op_key;
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_q.hit;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_data  = rsp_q.data;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;

`ifdef AA_TRACKER_SVA_EN
  logic              dup_keys;
  logic              sh_valid_q;
  logic [KEY_W-1:0]  sh_key_q;
  logic [DATA_W-1:0] sh_data_q;
  logic              chk_q;
  logic [DATA_W-1:0] chk_data_q;

  always_comb begin
    dup_keys = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = i + 1; j < DEPTH; j++) begin
        if (valid_q[i] && valid_q[j] && (key_q[i] == key_q[j])) dup_keys = 1'b1;
      end
    end
  end

  // Shadow of the most recent successful INSERT; a later LOOKUP of that key
  // with no DELETE/CLEAR in between must hit with the shadowed data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid_q <= 1'b0;
      sh_key_q   <= '0;
      sh_data_q  <= '0;
      chk_q      <= 1'b0;
      chk_data_q <= '0;
    end else begin
      chk_q      <= accept && (op == OP_LOOKUP) && sh_valid_q && (bus.op_key == sh_key_q);
      chk_data_q <= sh_data_q;
      if (accept) begin
        unique case (op)
          OP_INSERT: begin
            if (hit || free_valid) begin
              sh_valid_q <= 1'b1;
              sh_key_q   <= bus.op_key;
              sh_data_q  <= bus.op_data;
            end
          end
          OP_DELETE: if (bus.op_key == sh_key_q) sh_valid_q <= 1'b0;
          OP_CLEAR:  sh_valid_q <= 1'b0;
          OP_LOOKUP: ;
        endcase
      end
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH))
    else $error("aa_exists_tracker: count exceeds DEPTH");

  a_no_dup: assert property (@(posedge clk) disable iff (rst)
    !dup_keys)
    else $error("aa_exists_tracker: duplicate valid keys");

  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    rsp_valid_q && !bus.rsp_ready |=> rsp_valid_q && $stable(rsp_q))
    else $error("aa_exists_tracker: response changed while stalled");

  a_insert_lookup: assert property (@(posedge clk) disable iff (rst)
    chk_q |-> rsp_valid_q && rsp_q.hit && (rsp_q.data == chk_data_q))
    else $error("aa_exists_tracker: lookup after insert did not hit with inserted data");

  a_err_full: assert property (@(posedge clk) disable iff (rst)
    accept |=> (rsp_q.err -> $past(full_q)))
    else $error("aa_exists_tracker: rsp_err without full at accept");
`endif

endmodule

// File: tb/tb_aa_exists_tracker.sv
module tb_aa_exists_tracker;
  localparam int unsigned KEY_W  = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] count;
  logic full, empty;

  always #5 clk = ~clk;

  aa_exists_tracker_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) bus ();

  aa_exists_tracker #(
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  typedef struct {
    logic [1:0]  op;
    logic        hit;
    logic        err;
    logic [31:0] data;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  bit [31:0]   model [bit [31:0]];
  int          tests = 0;
  int          fails = 0;
  int unsigned acc_cnt = 0;
  int          ready_mode = 0;  // 0 always ready, 1 random, 2 stalled

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: an associative array with a capacity limit.
  task automatic model_apply(input logic [1:0] code, input bit [31:0] key, input bit [31:0] data);
    exp_t e;
    e.op = code; e.hit = 1'b0; e.err = 1'b0; e.data = '0;
    case (code)
      2'd0: if (model.exists(key)) begin e.hit = 1'b1; e.data = model[key]; end
      2'd1: begin
        if (model.exists(key)) begin
          e.hit = 1'b1; e.data = model[key]; model[key] = data;
        end else if (model.num() >= DEPTH) begin
          e.err = 1'b1;
        end else begin
          model[key] = data;
        end
      end
      2'd2: if (model.exists(key)) begin e.hit = 1'b1; e.data = model[key]; model.delete(key); end
      default: model.delete();
    endcase
    e.cnt = model.num();
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [1:0] code, input bit [31:0] key, input bit [31:0] data);
    int unsigned budget = 0;
    bit done = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_key   = key;
    bus.op_data  = data;
    while (!done) begin
      @(negedge clk);
      if (bus.op_ready) begin
        model_apply(code, key, data);
        acc_cnt++;
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 50) begin
          check("accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // rsp_ready driver
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented response is compared against the head of the
  // scoreboard; the entry is retired only when the response is consumed.
  initial begin
    int unsigned seen = 0;
    exp_t e;
    forever begin
      @(posedge clk); #3;
      if (rst) begin
        sb.delete();
        seen = acc_cnt;
      end else begin
        if (seen != acc_cnt) begin
          check("rsp_latency", 64'(bus.rsp_valid), 64'd1);
          seen = acc_cnt;
        end
        if (bus.rsp_valid) begin
          check("rsp_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb[0];
            check("rsp_hit",   64'(bus.rsp_hit),  64'(e.hit));
            check("rsp_err",   64'(bus.rsp_err),  64'(e.err));
            check("rsp_data",  64'(bus.rsp_data), 64'(e.data));
            check("count",     64'(count),        64'(e.cnt));
            check("full",      64'(full),         64'(e.cnt == DEPTH));
            check("empty",     64'(empty),        64'(e.cnt == 0));
            if (bus.rsp_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int unsigned r, wait_cyc;
    logic [1:0] code;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'd0;
    bus.op_key   = '0;
    bus.op_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_hit",   64'(bus.rsp_hit),   64'd0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_count",     64'(count),         64'd0);
    check("rst_empty",     64'(empty),         64'd1);
    check("rst_full",      64'(full),          64'd0);
    check("rst_op_ready",  64'(bus.op_ready),  64'd1);
    rst = 1'b0;

    // lookup on empty, insert then back-to-back lookup
    do_op(2'd0, 32'h10, 32'hDEAD);
    do_op(2'd1, 32'h10, 32'hAAAA);
    do_op(2'd0, 32'h10, 32'h0);

    // fill to capacity, overflow, free slot 3 (key 0x40) and re-insert
    for (int unsigned k = 2; k <= 8; k++) do_op(2'd1, k * 32'h10, 32'h1000 + k);
    do_op(2'd1, 32'h99, 32'h9999);
    do_op(2'd2, 32'h40, 32'h0);
    do_op(2'd1, 32'h99, 32'h9999);
    do_op(2'd0, 32'h99, 32'h0);

    // overwrite then delete
    do_op(2'd1, 32'h10, 32'hBBBB);
    do_op(2'd2, 32'h10, 32'h0);

    // stall the response path for 3 cycles with a request waiting
    idle(2);
    ready_mode = 2;
    idle(1);
    do_op(2'd0, 32'h20, 32'h0);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'd1;
    bus.op_key   = 32'h77;
    bus.op_data  = 32'h7777;
    repeat (3) begin
      @(negedge clk);
      check("stall_op_ready", 64'(bus.op_ready), 64'd0);
      @(posedge clk); #1;
    end
    ready_mode = 0;
    do_op(2'd1, 32'h77, 32'h7777);

    // reset with a pending response and 5 entries
    do_op(2'd3, 32'h0, 32'h0);
    for (int unsigned k = 0; k < 5; k++) do_op(2'd1, 32'h200 + k, 32'h500 + k);
    idle(2);
    ready_mode = 2;
    idle(1);
    do_op(2'd0, 32'h201, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_pend_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_pend_count",     64'(count),         64'd0);
    check("rst_pend_empty",     64'(empty),         64'd1);
    model.delete();
    rst = 1'b0;
    ready_mode = 0;
    idle(1);

    // refill then clear
    for (int unsigned k = 0; k < 3; k++) do_op(2'd1, 32'h300 + k, 32'h600 + k);
    do_op(2'd0, 32'h201, 32'h0);
    do_op(2'd3, 32'h0, 32'h0);
    do_op(2'd0, 32'h300, 32'h0);

    // randomized traffic over a small key space so hits and full are common
    ready_mode = 1;
    repeat (400) begin
      r = $urandom_range(0, 15);
      code = (r < 5) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      do_op(code, 32'h100 + $urandom_range(0, 11), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    ready_mode = 0;
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin
      idle(1);
      wait_cyc++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
